accum_ctrl: RTL and testbench
=============================

Name: accum_ctrl

Overview:
- Sequencing and accumulator stage wrapped around the team's 6-bit combinational ripple add/subtract unit.
- Accepts commands on a valid/ready handshake and drives the adder operands and select.
- Waits a programmable settle time, then captures the adder's sum and overflow into a registered accumulator.
- Sits between the command source (upstream) and the ripple adder, which it both feeds and consumes.

Parameters:
- WIDTH, 6: operand, accumulator and adder datapath width (two's complement).
- SETTLE_CYCLES, 2: cycles the adder inputs are held stable before capture; legal range is 1 or more.

Ports:
- clk  in  1  single system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  2  opcode: 00 LOAD, 01 ADD, 10 SUB, 11 CLEAR.
- cmd_data  in  WIDTH  operand for LOAD/ADD/SUB.
- add_x  out  WIDTH  adder x operand (current accumulator).
- add_y  out  WIDTH  adder y operand.
- add_sel  out  1  adder select: 0 add, 1 subtract (x - y).
- add_sum  in  WIDTH  adder result.
- add_overflow  in  1  adder signed-overflow flag.
- acc  out  WIDTH  accumulator value.
- ovf_flag  out  1  sticky overflow.
- res_valid  out  1  one-cycle pulse: acc was updated.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; acc, add_x and add_y are 0; add_sel, ovf_flag and res_valid are 0; cmd_ready is 0 while rst_n is low.
- A reset asserted mid-operation aborts the operation; no capture occurs.
- States: IDLE and SETTLE.
- cmd_ready is 1 only in IDLE with rst_n high. A command is accepted on the rising edge where cmd_valid and cmd_ready are both 1. cmd_valid/cmd_data/cmd_op are ignored outside IDLE.
- LOAD accepted at edge E: acc <= cmd_data and res_valid <= 1 at E; ovf_flag is unchanged; state stays IDLE.
- CLEAR accepted at edge E: acc <= 0, ovf_flag <= 0, res_valid <= 1 at E; state stays IDLE.
- ADD/SUB accepted at edge E0:
  - add_x <= acc, add_y <= cmd_data, add_sel <= (op == SUB).
  - Counter <= SETTLE_CYCLES-1; state <= SETTLE.
- In SETTLE, add_x/add_y/add_sel are held constant. Each edge: if counter == 0, capture; else decrement.
- Capture, at edge E0+SETTLE_CYCLES:
  - acc <= add_sum.
  - ovf_flag <= ovf_flag | add_overflow.
  - res_valid <= 1; state <= IDLE.
- res_valid is high for exactly one cycle after each LOAD, CLEAR or capture. cmd_ready is high in that same cycle, so back-to-back commands are accepted.
- ADD/SUB throughput: one per SETTLE_CYCLES+1 cycles. LOAD/CLEAR throughput: one per cycle.
- In IDLE, add_x/add_y/add_sel hold their last issued values. They do not track acc.
- Arithmetic wraps modulo 2^WIDTH. The carry-out is discarded; only add_overflow is recorded.

Optional Feature:
- Macro ACCUM_SATURATE_EN.
- Defined: at capture with add_overflow = 1, acc <= the saturated value instead of add_sum. On overflow the true result sign equals the sign of add_x:
  - add_x[WIDTH-1] == 0 -> maximum positive (011111 for WIDTH 6).
  - add_x[WIDTH-1] == 1 -> minimum negative (100000).
  - ovf_flag is still set.
- Not defined: wrapped add_sum is always stored. The saturation logic is absent.

Test Plan:
- Bench connects the team's 6-bit ripple add/sub unit to add_x/add_y/add_sel/add_sum/add_overflow.
- Scenario 1: LOAD 000001, then SUB 111111 -> res_valid exactly 2 cycles after SUB accept edge (SETTLE_CYCLES=2); acc 000010; ovf_flag 0.
- Scenario 2: LOAD 000011, then ADD 000010 -> acc 000101, ovf_flag 0; add_y stays 000010 and add_sel stays 0 throughout SETTLE.
- Scenario 3: LOAD 011111, then ADD 000001 -> without macro, acc 100000 and ovf_flag 1; with ACCUM_SATURATE_EN, acc 011111 and ovf_flag 1. Then LOAD 000000 -> ovf_flag still 1; then CLEAR -> acc 000000, ovf_flag 0.
- Scenario 4: hold cmd_valid high with ADD 000001 ×4 from acc 0 -> cmd_ready low during SETTLE; four captures spaced 3 cycles apart; acc ends at 000100; no command lost or duplicated.
- Scenario 5: LOAD 000101, ADD 000011, assert rst_n low one cycle into SETTLE -> acc, ovf_flag, res_valid, add_x and add_y read 0 immediately; after release, state IDLE and cmd_ready 1; no res_valid pulse.
- Scenario 6: LOAD 100000, then SUB 000001 -> without macro, acc 011111 and ovf_flag 1; with ACCUM_SATURATE_EN, acc 100000.

Source files
------------

// File: rtl/accum_ctrl.sv
// Command sequencer and registered accumulator around an external ripple add/subtract unit.
// Optional ACCUM_SATURATE_EN: clamp the captured result to max/min on signed overflow.
module accum_ctrl #(
  parameter int unsigned WIDTH         = 6,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] add_x,
  output logic [WIDTH-1:0] add_y,
  output logic             add_sel,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_overflow,
  output logic [WIDTH-1:0] acc,
  output logic             ovf_flag,
  output logic             res_valid
);

  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(SETTLE_CYCLES - 1);

  localparam logic [1:0] OpLoad  = 2'b00;
  localparam logic [1:0] OpAdd   = 2'b01;
  localparam logic [1:0] OpSub   = 2'b10;
  localparam logic [1:0] OpClear = 2'b11;

  typedef enum logic [0:0] {StIdle, StSettle} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             sel_q, sel_d;
  logic             ovf_q, ovf_d;
  logic             res_q, res_d;
  logic [WIDTH-1:0] capture_val;

`ifdef ACCUM_SATURATE_EN
  localparam logic [WIDTH-1:0] SatMax = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SatMin = {1'b1, {(WIDTH-1){1'b0}}};

  // On overflow the true result carries the sign of the x operand.
  always_comb begin
    capture_val = add_sum;
    if (add_overflow) begin
      capture_val = x_q[WIDTH-1] ? SatMin : SatMax;
    end
  end
`else
  always_comb begin
    capture_val = add_sum;
  end
`endif

  assign cmd_ready = (state_q == StIdle) && rst_n;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    x_d     = x_q;
    y_d     = y_q;
    sel_d   = sel_q;
    ovf_d   = ovf_q;
    res_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          unique case (cmd_op)
            OpLoad: begin
              acc_d = cmd_data;
              res_d = 1'b1;
            end
            OpClear: begin
              acc_d = '0;
              ovf_d = 1'b0;
              res_d = 1'b1;
            end
            OpAdd, OpSub: begin
              x_d     = acc_q;
              y_d     = cmd_data;
              sel_d   = (cmd_op == OpSub);
              cnt_d   = CntInit;
              state_d = StSettle;
            end
            default: ;
          endcase
        end
      end
      StSettle: begin
        if (cnt_q == '0) begin
          acc_d   = capture_val;
          ovf_d   = ovf_q | add_overflow;
          res_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      sel_q   <= 1'b0;
      ovf_q   <= 1'b0;
      res_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sel_q   <= sel_d;
      ovf_q   <= ovf_d;
      res_q   <= res_d;
    end
  end

  assign add_x     = x_q;
  assign add_y     = y_q;
  assign add_sel   = sel_q;
  assign acc       = acc_q;
  assign ovf_flag  = ovf_q;
  assign res_valid = res_q;

endmodule

// File: tb/tb_accum_ctrl.sv
// Bench for accum_ctrl: directed scenarios plus random commands against an integer model,
// with a behavioural 6-bit add/sub unit closing the loop.
module tb_accum_ctrl;

  localparam int unsigned W = 6;
  localparam int unsigned S = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'b00;
  logic [W-1:0] cmd_data = '0;
  logic [W-1:0] add_x, add_y, add_sum, acc;
  logic         add_sel, add_overflow, ovf_flag, res_valid;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  logic [W-1:0] m_acc = '0;
  logic         m_ovf = 1'b0;

  accum_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .add_x        (add_x),
    .add_y        (add_y),
    .add_sel      (add_sel),
    .add_sum      (add_sum),
    .add_overflow (add_overflow),
    .acc          (acc),
    .ovf_flag     (ovf_flag),
    .res_valid    (res_valid)
  );

  always #5 clk = ~clk;

  // Add/subtract unit: x + (sel ? ~y + 1 : y), signed overflow from operand/result signs.
  logic [W-1:0] y_eff;
  always_comb begin
    y_eff        = add_sel ? ~add_y : add_y;
    add_sum      = add_x + y_eff + {{(W-1){1'b0}}, add_sel};
    add_overflow = (add_x[W-1] == y_eff[W-1]) && (add_sum[W-1] != add_x[W-1]);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sval(input logic [W-1:0] v);
    return v[W-1] ? int'(v) - 64 : int'(v);
  endfunction

  // Reference: signed integer arithmetic, overflow when outside [-32, 31].
  task automatic model_apply(input logic [1:0] op, input logic [W-1:0] d);
    int r;
    logic [31:0] t;
    bit o;
    case (op)
      2'b00: m_acc = d;
      2'b11: begin m_acc = '0; m_ovf = 1'b0; end
      default: begin
        r = (op == 2'b01) ? sval(m_acc) + sval(d) : sval(m_acc) - sval(d);
        o = (r > 31) || (r < -32);
        t = r;
        m_acc = t[W-1:0];
`ifdef ACCUM_SATURATE_EN
        if (o) m_acc = (r > 31) ? 6'h1f : 6'h20;
`endif
        if (o) m_ovf = 1'b1;
      end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [W-1:0] d, input string tag);
    int n;
    logic [W-1:0] prev;
    cmd_op = op;
    cmd_data = d;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin step(); n++; end
    check({tag, " ready"}, 32'(cmd_ready), 32'd1);
    prev = m_acc;
    step();
    cmd_valid = 1'b0;
    cmd_data = $urandom;
    model_apply(op, d);
    if (op == 2'b00 || op == 2'b11) begin
      check({tag, " res_valid"}, 32'(res_valid), 32'd1);
    end else begin
      check({tag, " no early res"}, 32'(res_valid), 32'd0);
      check({tag, " busy"}, 32'(cmd_ready), 32'd0);
      check({tag, " add_x"}, 32'(add_x), 32'(prev));
      n = 0;
      while (!res_valid && n < 10) begin
        check({tag, " hold y"}, 32'(add_y), 32'(d));
        check({tag, " hold sel"}, 32'(add_sel), 32'(op == 2'b10));
        step();
        n++;
      end
      check({tag, " latency"}, 32'(n), 32'(S));
      check({tag, " ready w/ res"}, 32'(cmd_ready), 32'd1);
    end
    check({tag, " acc"}, 32'(acc), 32'(m_acc));
    check({tag, " ovf"}, 32'(ovf_flag), 32'(m_ovf));
    step();
    check({tag, " pulse"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    int caps[$];
    int accepts, low_cnt, pulses;
    bit pre;
    logic [1:0] rop;

    #2;
    check("rst acc", 32'(acc), 32'd0);
    check("rst ovf", 32'(ovf_flag), 32'd0);
    check("rst res", 32'(res_valid), 32'd0);
    check("rst ready", 32'(cmd_ready), 32'd0);
    check("rst x", 32'(add_x), 32'd0);
    check("rst y", 32'(add_y), 32'd0);
    check("rst sel", 32'(add_sel), 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    check("idle ready", 32'(cmd_ready), 32'd1);

    do_cmd(2'b00, 6'b000001, "s1 load");
    do_cmd(2'b10, 6'b111111, "s1 sub");
    check("s1 acc", 32'(acc), 32'h02);

    do_cmd(2'b00, 6'b000011, "s2 load");
    do_cmd(2'b01, 6'b000010, "s2 add");
    check("s2 acc", 32'(acc), 32'h05);

    do_cmd(2'b00, 6'b011111, "s3 load");
    do_cmd(2'b01, 6'b000001, "s3 add");
`ifdef ACCUM_SATURATE_EN
    check("s3 sat acc", 32'(acc), 32'h1f);
`else
    check("s3 wrap acc", 32'(acc), 32'h20);
`endif
    check("s3 ovf", 32'(ovf_flag), 32'd1);
    do_cmd(2'b00, 6'b000000, "s3 load0");
    check("s3 ovf sticky", 32'(ovf_flag), 32'd1);
    do_cmd(2'b11, 6'b000000, "s3 clear");
    check("s3 ovf cleared", 32'(ovf_flag), 32'd0);

    // Scenario 4: cmd_valid held high for four ADD 1 commands.
    cmd_op = 2'b01;
    cmd_data = 6'b000001;
    cmd_valid = 1'b1;
    accepts = 0;
    low_cnt = 0;
    for (int c = 0; c < 16; c++) begin
      pre = cmd_valid && cmd_ready;
      if (!cmd_ready) low_cnt++;
      step();
      if (pre) begin
        accepts++;
        model_apply(2'b01, 6'b000001);
      end
      if (accepts == 4) cmd_valid = 1'b0;
      if (res_valid) caps.push_back(c);
    end
    check("s4 accepts", 32'(accepts), 32'd4);
    check("s4 captures", 32'(caps.size()), 32'd4);
    check("s4 busy cycles", 32'(low_cnt), 32'(4 * S));
    for (int i = 1; i < caps.size(); i++) begin
      check("s4 spacing", 32'(caps[i] - caps[i-1]), 32'(S + 1));
    end
    check("s4 acc", 32'(acc), 32'h04);
    check("s4 model", 32'(acc), 32'(m_acc));

    // Scenario 5: reset one cycle into SETTLE.
    do_cmd(2'b00, 6'b000101, "s5 load");
    cmd_op = 2'b01;
    cmd_data = 6'b000011;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("s5 in settle", 32'(cmd_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("s5 acc", 32'(acc), 32'd0);
    check("s5 ovf", 32'(ovf_flag), 32'd0);
    check("s5 res", 32'(res_valid), 32'd0);
    check("s5 x", 32'(add_x), 32'd0);
    check("s5 y", 32'(add_y), 32'd0);
    check("s5 ready low", 32'(cmd_ready), 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    check("s5 ready", 32'(cmd_ready), 32'd1);
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (res_valid) pulses++;
    end
    check("s5 no pulse", 32'(pulses), 32'd0);
    m_acc = '0;
    m_ovf = 1'b0;

    do_cmd(2'b00, 6'b100000, "s6 load");
    do_cmd(2'b10, 6'b000001, "s6 sub");
`ifdef ACCUM_SATURATE_EN
    check("s6 sat acc", 32'(acc), 32'h20);
`else
    check("s6 wrap acc", 32'(acc), 32'h1f);
`endif
    check("s6 ovf", 32'(ovf_flag), 32'd1);

    // Random commands; CLEAR is made rarer so overflow stays sticky for a while.
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) rop = 2'b11;
      do_cmd(rop, 6'($urandom), "rand");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
